// File: rtl/simd_sub_serial.sv
// Bit-serial SIMD subtractor: a 16-bit a-b processed one 4-bit slice per cycle,
// with lanes of 4, 8 or 16 bits, signed/unsigned overflow and optional saturation.
module simd_sub_serial (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  width,
    input  logic        signed_mode,
    input  logic        saturate,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [3:0]  borrow_out,
    output logic [3:0]  overflow,
    output logic [3:0]  sat_hit
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [1:0]  width_q, width_d;
    logic        signed_q, signed_d;
    logic        sat_q, sat_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        bin_q, bin_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  borrow_q, borrow_d;
    logic [3:0]  ovf_q, ovf_d;
    logic [3:0]  sathit_q, sathit_d;

    // Index of the MSB slice of the lane that contains slice k
    function automatic logic [1:0] lane_msb(input logic [1:0] w, input logic [1:0] k);
        case (w)
            2'b00:   lane_msb = k;
            2'b01:   lane_msb = {k[1], 1'b1};
            default: lane_msb = 2'b11;
        endcase
    endfunction

    function automatic logic is_lsb(input logic [1:0] w, input logic [1:0] k);
        case (w)
            2'b00:   is_lsb = 1'b1;
            2'b01:   is_lsb = ~k[0];
            default: is_lsb = (k == 2'b00);
        endcase
    endfunction

    logic [3:0] a_s, b_s, clamp;
    logic [4:0] sub;
    logic       bin;
    logic [1:0] m, kk;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        width_d  = width_q;
        signed_d = signed_q;
        sat_d    = sat_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        result_d = result_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        sathit_d = sathit_q;
        a_s      = a_q[{cnt_q, 2'b00} +: 4];
        b_s      = b_q[{cnt_q, 2'b00} +: 4];
        bin      = is_lsb(width_q, cnt_q) ? 1'b0 : bin_q;
        sub      = {1'b0, a_s} - {1'b0, b_s} - {4'b0000, bin};
        clamp    = 4'h0;
        m        = 2'b00;
        kk       = 2'b00;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    width_d  = width;
                    signed_d = signed_mode;
                    sat_d    = saturate;
                    cnt_d    = 2'b00;
                    bin_d    = 1'b0;
                    borrow_d = 4'h0;
                    ovf_d    = 4'h0;
                    sathit_d = 4'h0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d[{cnt_q, 2'b00} +: 4] = sub[3:0];
                borrow_d[cnt_q] = sub[4];
                bin_d           = sub[4];
                if (lane_msb(width_q, cnt_q) == cnt_q)
                    ovf_d[cnt_q] = signed_q ? ((a_s[3] != b_s[3]) && (sub[3] != a_s[3])) : sub[4];
                else
                    ovf_d[cnt_q] = 1'b0;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'b11)
                    state_d = FIX;
            end
            FIX: begin
                // Every slice of an overflowed lane is rewritten; only the MSB slice differs in sign pattern
                sathit_d = 4'h0;
                for (int k = 0; k < 4; k++) begin
                    kk = 2'(k);
                    m  = lane_msb(width_q, kk);
                    if (sat_q && ovf_q[m]) begin
                        if (!signed_q)
                            clamp = 4'h0;
                        else if (a_q[{m, 2'b11}])
                            clamp = (m == kk) ? 4'h8 : 4'h0;
                        else
                            clamp = (m == kk) ? 4'h7 : 4'hF;
                        result_d[k*4 +: 4] = clamp;
                        sathit_d[m] = 1'b1;
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            width_q  <= '0;
            signed_q <= 1'b0;
            sat_q    <= 1'b0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            result_q <= '0;
            borrow_q <= '0;
            ovf_q    <= '0;
            sathit_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            width_q  <= width_d;
            signed_q <= signed_d;
            sat_q    <= sat_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            result_q <= result_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            sathit_q <= sathit_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign result     = result_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;
    assign sat_hit    = sathit_q;

endmodule

// File: tb/tb_simd_sub_serial.sv
// Directed bench for simd_sub_serial: vector table plus latency, backpressure
// and mid-operation reset sequences.
module tb_simd_sub_serial;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic [1:0]  width;
    logic        signed_mode;
    logic        saturate;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  borrow_out, overflow, sat_hit;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  width;
        logic        sgn;
        logic        sat;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] expResult;
        logic [3:0]  expBorrow;
        logic [3:0]  expOvf;
        logic [3:0]  expSat;
    } vec_t;

    vec_t vecs[11];

    simd_sub_serial dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .width      (width),
        .signed_mode(signed_mode),
        .saturate   (saturate),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .sat_hit    (sat_hit)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // Present one request, measure latency to out_valid, compare outputs, then drain
    task automatic applyStimulus(input vec_t v, input string tag);
        int edges;
        @(negedge clk);
        checkOutput({tag, " in_ready before"}, 32'(in_ready), 32'd1);
        width       = v.width;
        signed_mode = v.sgn;
        saturate    = v.sat;
        a           = v.a;
        b           = v.b;
        in_valid    = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        in_valid = 1'b0;
        a        = ~v.a;
        b        = ~v.b;
        width    = ~v.width;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            #1;
        end
        checkOutput({tag, " latency"}, 32'(edges), 32'd6);
        checkOutput({tag, " result"},  32'(result),     32'(v.expResult));
        checkOutput({tag, " borrow"},  32'(borrow_out), 32'(v.expBorrow));
        checkOutput({tag, " overflow"},32'(overflow),   32'(v.expOvf));
        checkOutput({tag, " sat_hit"}, 32'(sat_hit),    32'(v.expSat));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, " in_ready after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{2'b00, 1'b0, 1'b0, 16'h1234, 16'h0235, 16'h100F, 4'b0001, 4'b0001, 4'b0000};
        vecs[1]  = '{2'b10, 1'b0, 1'b0, 16'h1234, 16'h0235, 16'h0FFF, 4'b0111, 4'b0000, 4'b0000};
        vecs[2]  = '{2'b01, 1'b1, 1'b1, 16'h7F80, 16'h8001, 16'h7F80, 4'b1001, 4'b1010, 4'b1010};
        vecs[3]  = '{2'b01, 1'b1, 1'b0, 16'h7F80, 16'h8001, 16'hFF7F, 4'b1001, 4'b1010, 4'b0000};
        vecs[4]  = '{2'b10, 1'b0, 1'b1, 16'h0001, 16'h0002, 16'h0000, 4'b1111, 4'b1000, 4'b1000};
        vecs[5]  = '{2'b11, 1'b0, 1'b1, 16'h0001, 16'h0002, 16'h0000, 4'b1111, 4'b1000, 4'b1000};
        vecs[6]  = '{2'b00, 1'b1, 1'b1, 16'h8703, 16'h1800, 16'h8703, 4'b0100, 4'b1100, 4'b1100};
        vecs[7]  = '{2'b00, 1'b0, 1'b1, 16'h5A3C, 16'h6A2D, 16'h0010, 4'b1001, 4'b1001, 4'b1001};
        vecs[8]  = '{2'b10, 1'b1, 1'b1, 16'h8000, 16'h0001, 16'h8000, 4'b0111, 4'b1000, 4'b1000};
        vecs[9]  = '{2'b01, 1'b0, 1'b0, 16'h1020, 16'h2010, 16'hF010, 4'b1000, 4'b1000, 4'b0000};
        vecs[10] = '{2'b10, 1'b1, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 4'b1111, 4'b0000, 4'b0000};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; width = '0; signed_mode = 1'b0; saturate = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset in_ready",  32'(in_ready),  32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset result",    32'(result),    32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++)
            applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: out_ready held low while inputs are scrambled
        @(negedge clk);
        width = vecs[0].width; signed_mode = vecs[0].sgn; saturate = vecs[0].sat;
        a = vecs[0].a; b = vecs[0].b; in_valid = 1'b1;
        @(posedge clk);
        for (int e = 2; e <= 11; e++) begin
            #1;
            in_valid = $urandom_range(0, 1) == 1;
            a = 16'($urandom);
            b = 16'($urandom);
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp out_valid e%0d", e), 32'(out_valid), (e >= 6) ? 32'd1 : 32'd0);
            checkOutput($sformatf("bp in_ready e%0d", e), 32'(in_ready), 32'd0);
            if (e >= 6) begin
                checkOutput($sformatf("bp result e%0d", e), 32'(result), 32'h100F);
                checkOutput($sformatf("bp borrow e%0d", e), 32'({overflow, borrow_out}), 32'h11);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp release in_ready",  32'(in_ready),  32'd1);
        checkOutput("bp release out_valid", 32'(out_valid), 32'd0);

        // Reset while slice 2 is being processed, with a request held alongside it
        @(negedge clk);
        width = 2'b00; signed_mode = 1'b0; saturate = 1'b0;
        a = 16'h1234; b = 16'h0235; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("pre-reset partial result", 32'(result[7:0]), 32'h0F);
        reset = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrun in_ready",  32'(in_ready),  32'd1);
        checkOutput("midrun out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrun result",    32'(result),    32'd0);
        checkOutput("midrun flags",     32'({borrow_out, overflow, sat_hit}), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("reset blocks accept", 32'(in_ready), 32'd1);
        reset = 1'b0;
        in_valid = 1'b0;
        applyStimulus(vecs[2], "post-reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
